// File: rtl/acu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// acu : address control unit, 16-bit address register loaded bytewise from
//       the 8-bit data bus and driven onto the address bus through a tri-state.
// Rev 1.0
// ---------------------------------------------------------------------------
module acu #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic                  wl,
  input  logic                  wh,
  input  logic                  oe,
  output logic [ADDR_WIDTH-1:0] q
);

  // The register is exactly two data-bus bytes; anything else cannot be built.
  generate
    if (ADDR_WIDTH != 2 * DATA_WIDTH) begin : g_cfg_err
      $error("acu: ADDR_WIDTH must equal 2*DATA_WIDTH");
    end
  endgenerate

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;

  // Strobes are independent; both together load the same byte into each half.
  always_comb begin
    addr_d = addr_q;
    if (wl) begin
      addr_d[DATA_WIDTH-1:0] = d;
    end
    if (wh) begin
      addr_d[ADDR_WIDTH-1:DATA_WIDTH] = d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign q = oe ? addr_q : {ADDR_WIDTH{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_acu.sv
`default_nettype none
// Randomised scoreboard bench for acu: a byte-level reference model predicts
// the bus value, a negedge monitor pops predictions and compares.
module tb_acu;

  localparam int DW = 8;
  localparam int AW = 16;
  // Bus value seen when nobody drives: the bench net is weakly pulled high.
  localparam logic [AW-1:0] FLOAT = {AW{1'b1}};

  logic          clk;
  logic          rst;
  logic [DW-1:0] d;
  logic          wl;
  logic          wh;
  logic          oe;
  tri1  [AW-1:0] q_bus;

  acu #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .wl  (wl),
    .wh  (wh),
    .oe  (oe),
    .q   (q_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: two independent bytes.
  logic [DW-1:0] m_lo;
  logic [DW-1:0] m_hi;

  logic [AW-1:0] exp_q[$];
  string         name_q[$];
  int            n_checks;
  int            n_errors;

  // Monitor: one prediction per cycle, sampled mid-cycle away from the edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [AW-1:0] e;
      string         nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (q_bus !== e) begin
        n_errors++;
        $display("FAIL %s: q=%h expected %h at %0t", nm, q_bus, e, $time);
      end
    end
  end

  // Advance one edge in the model, then drive new inputs and predict the bus
  // value that must be present before the following edge.
  task automatic step(input logic rv, input logic [DW-1:0] dv, input logic wlv,
                      input logic whv, input logic oev, input string nm);
    @(posedge clk);
    if (rst === 1'b1) begin
      if (wl) m_lo = d;
      if (wh) m_hi = d;
    end else begin
      m_lo = '0;
      m_hi = '0;
    end
    #2;
    rst = rv;
    d   = dv;
    wl  = wlv;
    wh  = whv;
    oe  = oev;
    if (!rv) begin
      m_lo = '0;
      m_hi = '0;
    end
    exp_q.push_back(oev ? {m_hi, m_lo} : FLOAT);
    name_q.push_back(nm);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_lo = '0;
    m_hi = '0;
    rst = 1'b0;
    d   = '0;
    wl  = 1'b0;
    wh  = 1'b0;
    oe  = 1'b1;

    // Reset and byte loads
    step(1'b0, 8'h55, 1'b1, 1'b0, 1'b1, "rst_init");
    step(1'b1, 8'h64, 1'b1, 1'b0, 1'b1, "rst_release");
    step(1'b1, 8'h40, 1'b0, 1'b1, 1'b1, "load_lo");
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, "load_hi");
    for (int i = 0; i < 3; i++)
      step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1, "hold");

    // Output enable
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, "oe_off");
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, "oe_on");
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, "oe_off2");

    // Partial update while disabled
    step(1'b1, 8'h20, 1'b0, 1'b1, 1'b0, "wr_hi_disabled");
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, "partial_hi");

    // Simultaneous strobes
    step(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, "both_issue");
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, "both_strobes");

    // Restore 0x4064, then asynchronous reset between edges
    step(1'b1, 8'h64, 1'b1, 1'b0, 1'b1, "reload_issue");
    step(1'b1, 8'h40, 1'b0, 1'b1, 1'b1, "reload_lo");
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, "reload_hi");
    step(1'b0, 8'h55, 1'b1, 1'b0, 1'b1, "async_rst");
    step(1'b0, 8'h55, 1'b1, 1'b1, 1'b1, "rst_hold");
    step(1'b1, 8'h11, 1'b1, 1'b0, 1'b1, "rst_release2");
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, "post_rst_wl");

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) != 0), 8'($urandom), 1'($urandom),
           1'($urandom), ($urandom_range(0, 3) != 0), "random");
    end

    // Drain the scoreboard with a bounded wait
    begin
      int budget;
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/acu.md
Name: acu

Overview:
- Address control unit: a 16-bit address register assembled from an 8-bit data bus, one byte per write strobe.
- Drives the 16-bit address bus through a tri-state output enable.
- Sits between the 8-bit internal data bus and the shared address bus. Low and high bytes are written on separate cycles; the register is presented on the address bus only when enabled.

Parameters:
- DATA_WIDTH, 8: width of the data input d and of each register byte.
- ADDR_WIDTH, 16: width of the address register and q. Must equal 2*DATA_WIDTH; any other value is a configuration error.

Ports:
- clk  input  1  system clock; all register updates on the rising edge.
- rst  input  1  one clock; reset is asynchronous and active-low (rst=0 resets).
- d  input  DATA_WIDTH  byte to load into the low or high half of the register.
- wl  input  1  write-low strobe; loads d into reg[7:0] on the rising clk.
- wh  input  1  write-high strobe; loads d into reg[15:8] on the rising clk.
- oe  input  1  output enable for q.
- q  output  ADDR_WIDTH  tri-state address bus output.

Behaviour:
- Internal state is one ADDR_WIDTH register, split into a low byte reg[7:0] and a high byte reg[15:8].
- Reset:
  - rst=0 clears the register to 0x0000 immediately, without waiting for clk.
  - The register holds 0x0000 while rst=0; wl and wh are ignored during reset.
  - Reset release is synchronous-safe: the first load occurs on the first rising clk with rst=1.
- Write low: on a rising clk with rst=1 and wl=1, reg[7:0] <= d. reg[15:8] is unchanged.
- Write high: on a rising clk with rst=1 and wh=1, reg[15:8] <= d. reg[7:0] is unchanged.
- Simultaneous wl=1 and wh=1: both halves load the same d, so reg <= {d,d}.
- No strobe asserted: the register holds its value indefinitely.
- Write latency: one cycle. A byte written at edge N is visible on q (if oe=1) immediately after edge N.
- Output:
  - q is combinational from oe and the register.
  - oe=1: q = reg.
  - oe=0: q = all bits high-impedance (Z).
  - No clock latency on oe; q follows oe within the same cycle.
- oe is independent of reset. With oe=1 during reset, q drives 0x0000.
- Writing while oe=1 is legal; q updates right after the clock edge.
- No arithmetic, wrap-around or increment. The register is a pure two-byte latch.
- Inputs d, wl and wh are sampled only at rising clk. Glitches between edges have no effect.

Test Plan:
- Reset: rst=0 asserted mid-cycle with oe=1 and prior reg=0x4064 -> q becomes 0x0000 without a clock edge and stays 0x0000 while rst=0, even with wl=1 and d=0x55.
- Byte loads: rst=1, oe=1. d=100 (0x64) with wl=1 for one edge -> q=0x0064. Then d=64 (0x40) with wh=1 -> q=0x4064. Then strobes low for several cycles -> q holds 0x4064.
- Output enable: reg=0x4064. oe=0 -> q=16'hZZZZ. oe=1 -> q=0x4064 immediately. oe=0 -> Z again. Register content is unchanged throughout.
- Partial update while disabled: oe=0, d=32 (0x20), wh=1 for one edge, then wh=0 and oe=1 -> q=0x2064; low byte is preserved.
- Simultaneous strobes: d=0xA5, wl=wh=1 for one edge -> q=0xA5A5 with oe=1.
- Async reset mid-operation: with oe=1, assert rst=0 between clock edges -> q drops to 0x0000 before the next edge. Release rst=1, write wl with d=0x11 -> q=0x0011.
